pwm_capture: RTL and testbench

//   Receive-side counterpart of the PWM generator: measures an incoming PWM waveform.

---
 rtl/pwm_capture.sv | 126 ++++++++++++
 tb/tb_pwm_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: high time and period in clock cycles, one result per
// complete period, plus a sticky loss-of-signal flag with the level the line was stuck at.
module pwm_capture #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 10000000
) (
    input  logic             in_10MHz,
    input  logic             RESET_N,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             pwm_lost,
    output logic             lost_level
);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
    localparam int unsigned      SETTLE_W   = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [SETTLE_W-1:0]    r_settle;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_hcnt;
    logic [CNT_W-1:0]       r_pcnt;

    logic w_s;
    logic w_settled;
    logic w_rise;
    logic w_fall;
    logic w_rise_acc;
    logic w_timeout;

    // Synchroniser chain, delayed copy for edge detection, and a fill marker that tells
    // ARM when s and s_d reflect the real line rather than the reset value of the flops.
    always_ff @(posedge in_10MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync   <= '0;
            r_s_d    <= 1'b0;
            r_settle <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_s_d    <= w_s;
            r_settle <= {r_settle[SETTLE_W-2:0], 1'b1};
        end
    end

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_settled  = r_settle[SETTLE_W-1];
    assign w_rise     = w_s & ~r_s_d;
    assign w_fall     = ~w_s & r_s_d;
    assign w_rise_acc = w_rise & ((r_state == ST_WAIT) | (r_state == ST_LOW));
    // An accepted rise restarts the period, so it pre-empts a timeout in the same cycle.
    assign w_timeout  = (r_pcnt == LP_TIMEOUT) & ~w_rise_acc;

    // Measurement FSM with counters and registered outputs.
    always_ff @(posedge in_10MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_ARM;
            r_hcnt     <= LP_ZERO;
            r_pcnt     <= LP_ZERO;
            high_time  <= LP_ZERO;
            period     <= LP_ZERO;
            meas_valid <= 1'b0;
            pwm_lost   <= 1'b0;
            lost_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            r_pcnt     <= r_pcnt + LP_ONE;
            if (w_timeout) begin
                pwm_lost   <= 1'b1;
                lost_level <= w_s;
                r_pcnt     <= LP_ZERO;
                r_hcnt     <= LP_ZERO;
                r_state    <= w_s ? ST_ARM : ST_WAIT;
            end else begin
                case (r_state)
                    ST_ARM: begin
                        if (w_settled && !w_s) begin
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (w_rise) begin
                            r_hcnt  <= LP_ONE;
                            r_pcnt  <= LP_ONE;
                            r_state <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (w_fall) begin
                            r_state <= ST_LOW;
                        end else begin
                            r_hcnt <= r_hcnt + LP_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            high_time  <= r_hcnt;
                            period     <= r_pcnt;
                            meas_valid <= 1'b1;
                            pwm_lost   <= 1'b0;
                            r_hcnt     <= LP_ONE;
                            r_pcnt     <= LP_ONE;
                            r_state    <= ST_HIGH;
                        end
                    end
                    default: begin
                        r_state <= ST_ARM;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of steady waveforms plus hand-written sequences for
// reset-while-high, loss of signal (low and high), and asynchronous reset mid-pulse.
module tb_pwm_capture;

    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             pwm;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             meas_valid;
    logic             pwm_lost;
    logic             lost_level;

    pwm_capture #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .TIMEOUT    (1000)
    ) u_dut (
        .in_10MHz  (clk),
        .RESET_N   (rst_n),
        .pwm_in    (pwm),
        .high_time (high_time),
        .period    (period),
        .meas_valid(meas_valid),
        .pwm_lost  (pwm_lost),
        .lost_level(lost_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned hi;
        int unsigned lo;
        int unsigned reps;
        int unsigned exp_ht;
        int unsigned exp_per;
    } vec_t;

    vec_t        vecs [6];
    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned cyc_n;
    int unsigned mv_cnt;
    int unsigned last_mv_cyc;
    int unsigned exp_ht;
    int unsigned exp_per;
    int unsigned snap;
    int unsigned first_lost;
    logic        first_mv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // One clock with pwm driven to v; outputs sampled 1 ns after the edge.
    task automatic tick(input logic v);
        pwm = v;
        @(posedge clk);
        #1;
        cyc_n++;
        if (meas_valid) begin
            mv_cnt++;
            check("high_time", high_time, exp_ht);
            check("period", period, exp_per);
            check("lost_cleared_on_valid", {31'd0, pwm_lost}, 32'd0);
            if (!first_mv) begin
                check("valid_spacing", cyc_n - last_mv_cyc, exp_per);
            end
            first_mv    = 1'b0;
            last_mv_cyc = cyc_n;
        end
    endtask

    task automatic hold(input logic v, input int unsigned n);
        for (int i = 0; i < int'(n); i++) tick(v);
    endtask

    task automatic run(input int unsigned hi, input int unsigned lo, input int unsigned reps);
        for (int r = 0; r < int'(reps); r++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    task automatic do_reset(input logic lvl);
        rst_n = 1'b0;
        pwm   = lvl;
        #1;
        check("rst_high_time", high_time, 32'd0);
        check("rst_period", period, 32'd0);
        check("rst_flags", {29'd0, meas_valid, pwm_lost, lost_level}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        first_mv = 1'b1;
    endtask

    // Idle the line at v and record the cycle of the first pwm_lost (0 if none within the bound).
    task automatic wait_lost(input logic v);
        first_lost = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(v);
            if (pwm_lost && first_lost == 0) first_lost = cyc_n;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc_n = 0; mv_cnt = 0; last_mv_cyc = 0;
        first_mv = 1'b1; pwm = 1'b0; rst_n = 1'b0;
        exp_ht = 30; exp_per = 100;

        vecs[0] = '{hi: 30, lo: 70, reps: 4, exp_ht: 30, exp_per: 100};
        vecs[1] = '{hi: 1,  lo: 1,  reps: 6, exp_ht: 1,  exp_per: 2};
        vecs[2] = '{hi: 5,  lo: 3,  reps: 3, exp_ht: 5,  exp_per: 8};
        vecs[3] = '{hi: 70, lo: 30, reps: 2, exp_ht: 70, exp_per: 100};
        vecs[4] = '{hi: 1,  lo: 5,  reps: 3, exp_ht: 1,  exp_per: 6};
        vecs[5] = '{hi: 3,  lo: 1,  reps: 3, exp_ht: 3,  exp_per: 4};

        // Steady waveforms: one result per period, first one after the second rise.
        foreach (vecs[k]) begin
            do_reset(1'b0);
            exp_ht  = vecs[k].exp_ht;
            exp_per = vecs[k].exp_per;
            snap    = mv_cnt;
            hold(1'b0, 5);
            hold(1'b1, vecs[k].hi);
            check("no_valid_before_2nd_rise", mv_cnt - snap, 32'd0);
            hold(1'b0, vecs[k].lo);
            run(vecs[k].hi, vecs[k].lo, vecs[k].reps - 1);
            hold(1'b1, 6);
            hold(1'b0, 4);
            check("valid_count", mv_cnt - snap, vecs[k].reps);
            check("lost_idle", {31'd0, pwm_lost}, 32'd0);
        end

        // Line high while reset releases: first result only after low, rise, fall, rise.
        exp_ht = 30; exp_per = 100;
        do_reset(1'b1);
        snap = mv_cnt;
        hold(1'b1, 20);
        hold(1'b0, 40);
        check("no_valid_from_reset_high", mv_cnt - snap, 32'd0);
        run(30, 70, 2);
        hold(1'b1, 6);
        check("reset_high_valid_count", mv_cnt - snap, 32'd2);

        // Loss of signal with line low, then recovery.
        do_reset(1'b0);
        hold(1'b0, 5);
        run(30, 70, 3);
        wait_lost(1'b0);
        check("lost_low_delay", first_lost - last_mv_cyc, 32'd1000);
        check("lost_low_flag", {31'd0, pwm_lost}, 32'd1);
        check("lost_low_level", {31'd0, lost_level}, 32'd0);
        snap     = mv_cnt;
        first_mv = 1'b1;
        hold(1'b1, 30);
        check("lost_held_until_valid", {31'd0, pwm_lost}, 32'd1);
        hold(1'b0, 70);
        hold(1'b1, 6);
        check("recover_low_count", mv_cnt - snap, 32'd1);
        check("recover_low_lost", {31'd0, pwm_lost}, 32'd0);

        // Loss of signal with line stuck high: re-fires, recovers only after the line drops.
        do_reset(1'b0);
        hold(1'b0, 5);
        run(30, 70, 2);
        wait_lost(1'b1);
        check("lost_high_delay", first_lost - last_mv_cyc, 32'd1000);
        check("lost_high_level", {31'd0, lost_level}, 32'd1);
        snap = mv_cnt;
        hold(1'b1, 1500);
        check("stuck_high_no_valid", mv_cnt - snap, 32'd0);
        check("stuck_high_lost", {31'd0, pwm_lost}, 32'd1);
        check("stuck_high_level", {31'd0, lost_level}, 32'd1);
        first_mv = 1'b1;
        hold(1'b0, 50);
        run(30, 70, 1);
        hold(1'b1, 6);
        check("recover_high_count", mv_cnt - snap, 32'd1);
        check("recover_high_lost", {31'd0, pwm_lost}, 32'd0);

        // Asynchronous reset in the middle of a high pulse discards the partial period.
        do_reset(1'b0);
        hold(1'b0, 5);
        run(30, 70, 2);
        hold(1'b1, 10);
        check("pre_reset_high_time", high_time, 32'd30);
        do_reset(1'b1);
        snap = mv_cnt;
        hold(1'b1, 20);
        hold(1'b0, 70);
        run(30, 70, 1);
        check("post_reset_no_partial", mv_cnt - snap, 32'd0);
        hold(1'b1, 6);
        check("post_reset_count", mv_cnt - snap, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
